axil_write_issue: RTL and testbench

Upstream stage of the AXI-Lite write master: accepts a single write request (address, data, strobes) from the user side, drives the AW and W channels with independent VALID/READY handshakes, and emits a one-cycle `done` pulse when both channels have completed. `done` connects directly to the `start` input of the B-channel responder stage, which then collects the write response. One outstanding write at a time. Includes a handshake watchdog.

---
 rtl/axil_write_issue.sv | 139 +++++++++++++
 tb/tb_axil_write_issue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axil_write_issue.sv
// rtl/axil_write_issue.sv - AXI-Lite write issue stage: drives AW and W for one write, pulses done when both complete
module axil_write_issue #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data,
    input  logic [DATA_W/8-1:0]   strb,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam bit   WD_EN  = (TIMEOUT_CYCLES > 0);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              aw_done;
    logic              w_done;
    logic [WD_W-1:0]   wd_cnt;
    logic              aw_hs;
    logic              w_hs;
    logic              accept;
    logic              complete;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign awprot = 3'b000;
    assign busy   = (state == SEND);

    // Next-state: accept a request only when idle; finish once both channels have handshaken
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the request and run the two channel handshakes independently
    always_ff @(posedge clk) begin
        if (reset) begin
            awaddr  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (accept) begin
            awaddr  <= addr;
            wdata   <= data;
            wstrb   <= STRB_W'(strb);
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == SEND) begin
            if (aw_hs) begin
                awvalid <= 1'b0;
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                wvalid <= 1'b0;
                w_done <= 1'b1;
            end
        end
    end

    // Completion pulse feeds the B-channel stage directly
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= complete;
        end
    end

    // Watchdog: count SEND cycles, saturate, pulse once when the limit is reached
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (accept) begin
                wd_cnt <= '0;
            end else if (WD_EN && (state == SEND) && (wd_cnt != WD_MAX)) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_MAX - 1'b1) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_write_issue.sv
// tb/tb_axil_write_issue.sv - directed self-checking bench for axil_write_issue
module tb_axil_write_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int to_cnt = 0;
    int d0;
    int t0;

    axil_write_issue #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .addr(addr),
        .data(data),
        .strb(strb),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .awaddr(awaddr),
        .awprot(awprot),
        .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata),
        .wstrb(wstrb),
        .wvalid(wvalid),
        .wready(wready)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (timeout) to_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; addr = '0; data = '0; strb = '0;
        awready = 1'b0; wready = 1'b0;
        tick();
        tick();
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wstrb", wstrb, 0);
        chk("awprot", awprot, 0);
        reset = 1'b0;
        tick();

        // Basic write, both ready
        d0 = done_cnt;
        addr = 32'h10; data = 32'hDEADBEEF; strb = 4'hF; start = 1'b1;
        awready = 1'b1; wready = 1'b1;
        tick();
        start = 1'b0;
        chk("basic_awvalid", awvalid, 1);
        chk("basic_wvalid", wvalid, 1);
        chk("basic_busy", busy, 1);
        chk("basic_awaddr", awaddr, 32'h10);
        chk("basic_wdata", wdata, 32'hDEADBEEF);
        chk("basic_wstrb", wstrb, 4'hF);
        chk("basic_done_early", done, 0);
        tick();
        chk("basic_done", done, 1);
        chk("basic_busy_low", busy, 0);
        chk("basic_awvalid_low", awvalid, 0);
        chk("basic_wvalid_low", wvalid, 0);
        tick();
        chk("basic_done_once", done, 0);
        chk("basic_done_count", done_cnt - d0, 1);

        // Skewed: AW held off for 4 cycles
        d0 = done_cnt;
        addr = 32'h44; data = 32'h12345678; strb = 4'h3; start = 1'b1;
        awready = 1'b0; wready = 1'b1;
        tick();
        start = 1'b0;
        chk("skew_awvalid_c1", awvalid, 1);
        chk("skew_wvalid_c1", wvalid, 1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk($sformatf("skew_awvalid_c%0d", i), awvalid, 1);
            chk($sformatf("skew_wvalid_c%0d", i), wvalid, 0);
            chk($sformatf("skew_awaddr_c%0d", i), awaddr, 32'h44);
            chk($sformatf("skew_done_c%0d", i), done, 0);
        end
        awready = 1'b1;
        tick();
        chk("skew_done", done, 1);
        chk("skew_awvalid_low", awvalid, 0);
        chk("skew_wstrb", wstrb, 4'h3);
        tick();
        chk("skew_done_count", done_cnt - d0, 1);

        // Reverse skew: W held off for 3 cycles
        d0 = done_cnt;
        addr = 32'h88; data = 32'hCAFEF00D; strb = 4'hC; start = 1'b1;
        awready = 1'b1; wready = 1'b0;
        tick();
        start = 1'b0;
        chk("rev_both_valid", {awvalid, wvalid}, 2'b11);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("rev_awvalid_c%0d", i), awvalid, 0);
            chk($sformatf("rev_wvalid_c%0d", i), wvalid, 1);
            chk($sformatf("rev_done_c%0d", i), done, 0);
        end
        wready = 1'b1;
        tick();
        chk("rev_done", done, 1);
        chk("rev_wvalid_low", wvalid, 0);
        tick();
        chk("rev_done_count", done_cnt - d0, 1);

        // Start during SEND is ignored
        d0 = done_cnt;
        addr = 32'h10; data = 32'hA5A5A5A5; strb = 4'h5; start = 1'b1;
        awready = 1'b0; wready = 1'b0;
        tick();
        addr = 32'h20; data = 32'h0; strb = 4'hF;
        tick();
        start = 1'b0;
        chk("ign_awaddr", awaddr, 32'h10);
        chk("ign_wdata", wdata, 32'hA5A5A5A5);
        chk("ign_wstrb", wstrb, 4'h5);
        awready = 1'b1; wready = 1'b1;
        tick();
        chk("ign_done", done, 1);
        chk("ign_awaddr_hold", awaddr, 32'h10);
        tick();
        chk("ign_no_second_busy", busy, 0);
        tick();
        chk("ign_no_second_valid", awvalid, 0);
        chk("ign_done_count", done_cnt - d0, 1);

        // Watchdog: limit 8, readies low for 12 cycles
        d0 = done_cnt; t0 = to_cnt;
        addr = 32'h55; data = 32'h1; strb = 4'h1; start = 1'b1;
        awready = 1'b0; wready = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            start = 1'b0;
            chk($sformatf("wd_valids_c%0d", i), {awvalid, wvalid}, 2'b11);
            chk($sformatf("wd_timeout_c%0d", i), timeout, (i == 9) ? 1 : 0);
            chk($sformatf("wd_done_c%0d", i), done, 0);
        end
        awready = 1'b1; wready = 1'b1;
        tick();
        chk("wd_done", done, 1);
        chk("wd_timeout_quiet", timeout, 0);
        tick();
        chk("wd_timeout_count", to_cnt - t0, 1);
        chk("wd_done_count", done_cnt - d0, 1);

        // Reset mid-transaction
        d0 = done_cnt;
        addr = 32'h99; data = 32'h77; strb = 4'h2; start = 1'b1;
        awready = 1'b0; wready = 1'b0;
        tick();
        start = 1'b0;
        chk("mid_awvalid", awvalid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valids", {awvalid, wvalid}, 2'b00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_timeout", timeout, 0);
        chk("mid_rst_awaddr", awaddr, 0);
        awready = 1'b1; wready = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_no_done", done_cnt - d0, 0);
        addr = 32'h30; data = 32'hBEEF0001; strb = 4'h9; start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_awaddr", awaddr, 32'h30);
        chk("post_valids", {awvalid, wvalid}, 2'b11);
        tick();
        chk("post_done", done, 1);
        tick();
        chk("post_done_count", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
